// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding, cycle counter width,
// and the registered output bundle decoded from the sequencer state.
package pll_seq_pkg;

   localparam int unsigned CNT_W        = 20;
   localparam int unsigned RETRY_W      = 4;
   localparam int unsigned LOSS_W       = 8;

   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [RETRY_W-1:0] retry_t;
   typedef logic [LOSS_W-1:0]  loss_t;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAILED    = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic pll_rst;
      logic domain_rst;
      logic ready;
      logic fail;
   } seq_out_t;

   // Output levels that belong to a state; used to load the output flops.
   function automatic seq_out_t decode_outputs(input seq_state_e s);
      seq_out_t o;
      o = '{pll_rst: 1'b0, domain_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      case (s)
         PLL_RESET: o.pll_rst = 1'b1;
         WAIT_LOCK,
         STABILIZE: o.pll_rst = 1'b0;
         RUN: begin
            o.domain_rst = 1'b0;
            o.ready      = 1'b1;
         end
         FAILED: begin
            o.pll_rst = 1'b1;
            o.fail    = 1'b1;
         end
         default: o.pll_rst = 1'b1;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for and qualifies lock, then releases the PLL-clock
// domain; retries failed attempts and latches FAILED after too many.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 7
) (
   input  logic               refclk,
   input  logic               rst,
   output logic               pll_rst,
   input  logic               locked,
   output logic               domain_rst,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_count,
   output logic [LOSS_W-1:0]  lock_loss_count
);

   localparam cnt_t   RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam cnt_t   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that first sees lk=1 counts as the first stable cycle.
   localparam cnt_t   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 2);
   localparam retry_t RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   seq_state_e state;
   seq_state_e next_state;
   cnt_t       cnt;
   logic       lk;
   logic       attempt_fail;
   logic       lock_lost;
   retry_t     retry_inc;
   seq_out_t   out_d;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked),
      .q   (lk)
   );

   assign retry_inc = retry_count + retry_t'(1);

   // State register
   always_ff @(posedge refclk) begin
      if (rst) state <= PLL_RESET;
      else     state <= next_state;
   end

   // Next-state logic; a lk change always wins over a counter expiry
   always_comb begin
      next_state   = state;
      attempt_fail = 1'b0;
      lock_lost    = 1'b0;
      case (state)
         PLL_RESET: begin
            if (cnt == RST_LAST) next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lk)                       next_state   = STABILIZE;
            else if (cnt == TIMEOUT_LAST) attempt_fail = 1'b1;
         end
         STABILIZE: begin
            if (!lk)                     attempt_fail = 1'b1;
            else if (cnt == STABLE_LAST) next_state   = RUN;
         end
         RUN: begin
            if (!lk) begin
               lock_lost  = 1'b1;
               next_state = PLL_RESET;
            end
         end
         FAILED:  next_state = FAILED;
         default: next_state = PLL_RESET;
      endcase
      if (attempt_fail) next_state = (retry_inc == RETRY_LIMIT) ? FAILED : PLL_RESET;
   end

   // Output decode from the upcoming state so flops track the state exactly
   always_comb begin
      out_d = decode_outputs(next_state);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst    <= 1'b1;
         domain_rst <= 1'b1;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         pll_rst    <= out_d.pll_rst;
         domain_rst <= out_d.domain_rst;
         ready      <= out_d.ready;
         fail       <= out_d.fail;
      end
   end

   // Shared cycle counter, cleared on each state entry, held at all-ones
   always_ff @(posedge refclk) begin
      if (rst)                      cnt <= '0;
      else if (next_state != state) cnt <= '0;
      else if (cnt != '1)           cnt <= cnt + cnt_t'(1);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         retry_count     <= '0;
         lock_loss_count <= '0;
      end else begin
         if (attempt_fail) retry_count <= retry_inc;
         if (lock_lost && (lock_loss_count != '1))
            lock_loss_count <= lock_loss_count + loss_t'(1);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters (4/20/8/3).
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst    = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst, domain_rst, ready, fail;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   int errors = 0;
   int checks = 0;
   int n;
   logic ready_seen;

   pll_reset_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .pll_rst         (pll_rst),
      .locked          (locked),
      .domain_rst      (domain_rst),
      .ready           (ready),
      .fail            (fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   always #10 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".pll_rst"},    32'(pll_rst),         32'd1);
      check({tag, ".domain_rst"}, 32'(domain_rst),      32'd1);
      check({tag, ".ready"},      32'(ready),           32'd0);
      check({tag, ".fail"},       32'(fail),            32'd0);
      check({tag, ".retry"},      32'(retry_count),     32'd0);
      check({tag, ".loss"},       32'(lock_loss_count), 32'd0);
   endtask

   // Number of samples (starting now) for which pll_rst stays high
   task automatic count_pll_rst_high(output int cnt);
      cnt = 0;
      while (pll_rst === 1'b1 && cnt < 50) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_ready(input logic v, input int max, output int cnt);
      cnt = 0;
      while (ready !== v && cnt < max) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_retry_change(input logic [3:0] old, output int cnt);
      cnt = 0;
      while (retry_count === old && cnt < 60) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check_reset_values("reset");

      // Nominal: 4-cycle pulse, lock 3 cycles after release, ready 10 edges after locked
      rst = 1'b0;
      count_pll_rst_high(n);
      check("nom.pulse_len", 32'(n), 32'd4);
      repeat (3) tick();
      locked = 1'b1;
      wait_ready(1'b1, 30, n);
      check("nom.ready_latency", 32'(n), 32'd10);
      check("nom.domain_rst", 32'(domain_rst), 32'd0);
      check("nom.retry", 32'(retry_count), 32'd0);
      check("nom.fail", 32'(fail), 32'd0);

      // Lock loss in RUN: lk falls two edges after locked, outputs follow on the next edge
      locked = 1'b0;
      tick();
      tick();
      check("loss.domain_rst_before", 32'(domain_rst), 32'd0);
      tick();
      check("loss.domain_rst", 32'(domain_rst), 32'd1);
      check("loss.ready", 32'(ready), 32'd0);
      check("loss.count", 32'(lock_loss_count), 32'd1);
      check("loss.retry", 32'(retry_count), 32'd0);
      check("loss.pll_rst", 32'(pll_rst), 32'd1);
      locked = 1'b1;
      wait_ready(1'b1, 40, n);
      check("loss.relock_ready", 32'(ready), 32'd1);

      // Stabilize glitch on the final stable cycle: failure wins over completion
      rst = 1'b1;
      locked = 1'b0;
      tick();
      check_reset_values("rst2");
      rst = 1'b0;
      count_pll_rst_high(n);
      check("glitch.pulse_len", 32'(n), 32'd4);
      locked = 1'b1;
      ready_seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         ready_seen |= ready;
      end
      locked = 1'b0;
      tick();
      ready_seen |= ready;
      locked = 1'b1;
      tick();
      ready_seen |= ready;
      check("glitch.retry_before", 32'(retry_count), 32'd0);
      tick();
      ready_seen |= ready;
      check("glitch.retry", 32'(retry_count), 32'd1);
      check("glitch.pll_rst", 32'(pll_rst), 32'd1);
      check("glitch.ready_seen", 32'(ready_seen), 32'd0);
      count_pll_rst_high(n);
      check("glitch.new_pulse_len", 32'(n), 32'd4);
      wait_ready(1'b1, 30, n);
      check("glitch.relock_latency", 32'(n), 32'd8);
      check("glitch.retry_kept", 32'(retry_count), 32'd1);

      // Single-cycle glitch in RUN is a full lock loss
      locked = 1'b0;
      tick();
      locked = 1'b1;
      wait_ready(1'b0, 6, n);
      check("run_glitch.ready", 32'(ready), 32'd0);
      check("run_glitch.loss", 32'(lock_loss_count), 32'd1);
      check("run_glitch.retry", 32'(retry_count), 32'd1);

      // Mid-operation reset while in STABILIZE
      count_pll_rst_high(n);
      check("midrst.pre_pulse_len", 32'(n), 32'd4);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_reset_values("midrst");
      rst = 1'b0;
      count_pll_rst_high(n);
      check("midrst.pulse_len", 32'(n), 32'd4);

      // Saturation of lock_loss_count over 260 RUN losses
      wait_ready(1'b1, 40, n);
      check("sat.start_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 260; i++) begin
         locked = 1'b0;
         tick();
         locked = 1'b1;
         wait_ready(1'b0, 6, n);
         if (ready !== 1'b0) begin
            check("sat.drop_timeout", 32'(ready), 32'd0);
            break;
         end
         if (i == 9) check("sat.count10", 32'(lock_loss_count), 32'd10);
         wait_ready(1'b1, 40, n);
         if (ready !== 1'b1) begin
            check("sat.relock_timeout", 32'(ready), 32'd1);
            break;
         end
      end
      check("sat.count", 32'(lock_loss_count), 32'd255);
      check("sat.retry", 32'(retry_count), 32'd0);

      // Timeout: three 24-cycle attempts, then FAILED for good
      rst = 1'b1;
      locked = 1'b0;
      tick();
      check_reset_values("rst3");
      rst = 1'b0;
      wait_retry_change(4'd0, n);
      check("to.first_interval", 32'(n), 32'd24);
      check("to.retry1", 32'(retry_count), 32'd1);
      check("to.pll_rst1", 32'(pll_rst), 32'd1);
      wait_retry_change(4'd1, n);
      check("to.second_interval", 32'(n), 32'd24);
      check("to.retry2", 32'(retry_count), 32'd2);
      check("to.fail2", 32'(fail), 32'd0);
      wait_retry_change(4'd2, n);
      check("to.third_interval", 32'(n), 32'd24);
      check("to.retry3", 32'(retry_count), 32'd3);
      check("to.fail", 32'(fail), 32'd1);
      check("to.pll_rst", 32'(pll_rst), 32'd1);
      check("to.domain_rst", 32'(domain_rst), 32'd1);
      locked = 1'b1;
      repeat (40) tick();
      check("to.fail_held", 32'(fail), 32'd1);
      check("to.pll_rst_held", 32'(pll_rst), 32'd1);
      check("to.domain_rst_held", 32'(domain_rst), 32'd1);
      check("to.ready_held", 32'(ready), 32'd0);
      check("to.retry_held", 32'(retry_count), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
